// File: rtl/w0rm_core_branch_unit_if.sv
// Handshake and result bundle between the W0RM front end and its branch unit.
// out_misalign is present only when W0RM_BRANCH_ALIGN_CHECK_EN is defined.
interface w0rm_core_branch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  is_branch;
  logic [3:0]            cond_code;
  logic [1:0]            target_mode;
  logic                  link_en;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [DATA_WIDTH-1:0] rn;
  logic [DATA_WIDTH-1:0] lit;
  logic                  flag_z;
  logic                  flag_n;
  logic                  flag_c;
  logic                  flag_v;
  logic                  flush_in;
  logic [USER_WIDTH-1:0] user_in;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_taken;
  logic [ADDR_WIDTH-1:0] out_target;
  logic [DATA_WIDTH-1:0] out_link;
  logic                  out_link_we;
  logic                  flush_pipeline;
  logic [USER_WIDTH-1:0] user_out;
`ifdef W0RM_BRANCH_ALIGN_CHECK_EN
  logic                  out_misalign;
`endif

  modport master (
    output in_valid, is_branch, cond_code, target_mode, link_en, base_addr, rn, lit,
           flag_z, flag_n, flag_c, flag_v, flush_in, user_in, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_link, out_link_we,
           flush_pipeline, user_out
`ifdef W0RM_BRANCH_ALIGN_CHECK_EN
    , input out_misalign
`endif
  );

  modport slave (
    input  in_valid, is_branch, cond_code, target_mode, link_en, base_addr, rn, lit,
           flag_z, flag_n, flag_c, flag_v, flush_in, user_in, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_link, out_link_we,
           flush_pipeline, user_out
`ifdef W0RM_BRANCH_ALIGN_CHECK_EN
    , output out_misalign
`endif
  );
endinterface

// File: rtl/w0rm_core_branch_unit.sv
// Two-stage W0RM branch resolution: S1 captures operands/flags, S2 holds the resolved result.
// Define W0RM_BRANCH_ALIGN_CHECK_EN to report misaligned taken targets instead of taking them.
module w0rm_core_branch_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int USER_WIDTH  = 1,
  parameter int INSTR_BYTES = 2
) (
  input logic                    clk,
  input logic                    reset_n,
  w0rm_core_branch_unit_if.slave bus
);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    logic                  is_branch;
    logic [3:0]            cond_code;
    logic [1:0]            target_mode;
    logic                  link_en;
    addr_t                 base_addr;
    data_t                 rn;
    data_t                 lit;
    logic                  z;
    logic                  n;
    logic                  c;
    logic                  v;
    logic [USER_WIDTH-1:0] user;
  } s1_t;

  typedef struct packed {
    logic                  taken;
    addr_t                 target;
    data_t                 link;
    logic                  link_we;
    logic                  misalign;
    logic [USER_WIDTH-1:0] user;
  } s2_t;

  logic  s1_valid_q, s1_valid_d;
  logic  s2_valid_q, s2_valid_d;
  s1_t   s1_q, s1_d;
  s2_t   s2_q, s2_d;
  logic  s2_adv, s1_adv;
  logic  cond_hit, taken_raw, taken_fin, misalign;
  addr_t target_calc, link_addr;

  assign s2_adv = !s2_valid_q || bus.out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  always_comb begin
    cond_hit = 1'b0;
    case (s1_q.cond_code)
      4'd0:  cond_hit = s1_q.z;
      4'd1:  cond_hit = !s1_q.z;
      4'd2:  cond_hit = s1_q.c;
      4'd3:  cond_hit = !s1_q.c;
      4'd4:  cond_hit = s1_q.v;
      4'd5:  cond_hit = !s1_q.v;
      4'd6:  cond_hit = s1_q.n;
      4'd7:  cond_hit = !s1_q.n;
      4'd8:  cond_hit = s1_q.c && !s1_q.z;
      4'd9:  cond_hit = !s1_q.c || s1_q.z;
      4'd10: cond_hit = (s1_q.n == s1_q.v);
      4'd11: cond_hit = (s1_q.n != s1_q.v);
      4'd12: cond_hit = !s1_q.z && (s1_q.n == s1_q.v);
      4'd13: cond_hit = s1_q.z || (s1_q.n != s1_q.v);
      4'd14: cond_hit = 1'b1;
      4'd15: cond_hit = 1'b0;
    endcase

    target_calc = '0;
    case (s1_q.target_mode)
      2'd0:    target_calc = s1_q.rn[ADDR_WIDTH-1:0];
      2'd1:    target_calc = s1_q.base_addr + s1_q.lit[ADDR_WIDTH-1:0];
      2'd2:    target_calc = s1_q.rn[ADDR_WIDTH-1:0] + s1_q.lit[ADDR_WIDTH-1:0];
      default: target_calc = '0;
    endcase

    link_addr = s1_q.base_addr + addr_t'(INSTR_BYTES);
    taken_raw = s1_q.is_branch && cond_hit && (s1_q.target_mode != 2'd3);
`ifdef W0RM_BRANCH_ALIGN_CHECK_EN
    misalign  = taken_raw && |(target_calc & addr_t'(INSTR_BYTES - 1));
`else
    misalign  = 1'b0;
`endif
    taken_fin = taken_raw && !misalign;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d = '{is_branch: bus.is_branch, cond_code: bus.cond_code,
                 target_mode: bus.target_mode, link_en: bus.link_en,
                 base_addr: bus.base_addr, rn: bus.rn, lit: bus.lit,
                 z: bus.flag_z, n: bus.flag_n, c: bus.flag_c, v: bus.flag_v,
                 user: bus.user_in};
      end
    end

    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_d       = '0;
      if (s1_valid_q) begin
        // target survives a misalign report so trap logic can see it
        s2_d.taken    = taken_fin;
        s2_d.target   = taken_raw ? target_calc : '0;
        s2_d.link     = taken_fin ? data_t'(link_addr) : '0;
        s2_d.link_we  = taken_fin && s1_q.link_en;
        s2_d.misalign = misalign;
        s2_d.user     = s1_q.user;
      end
    end

    if (bus.flush_in) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.in_ready       = s1_adv;
  assign bus.out_valid      = s2_valid_q;
  assign bus.out_taken      = s2_q.taken;
  assign bus.out_target     = s2_q.target;
  assign bus.out_link       = s2_q.link;
  assign bus.out_link_we    = s2_q.link_we;
  assign bus.user_out       = s2_q.user;
  assign bus.flush_pipeline = s2_valid_q && bus.out_ready && s2_q.taken && !bus.flush_in;
`ifdef W0RM_BRANCH_ALIGN_CHECK_EN
  assign bus.out_misalign   = s2_q.misalign;
`endif
endmodule

// File: tb/tb_w0rm_core_branch_unit.sv
// Self-checking bench for w0rm_core_branch_unit: directed scenarios plus a randomized scoreboard run.
// Honours W0RM_BRANCH_ALIGN_CHECK_EN the same way as the design.
module tb_w0rm_core_branch_unit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int UW = 3;
  localparam int IB = 2;
  localparam int VW = 1 + AW + DW + 1 + UW + 1;

  typedef struct {
    logic          is_branch;
    logic [3:0]    cc;
    logic [1:0]    mode;
    logic          link_en;
    logic [AW-1:0] base;
    logic [DW-1:0] rn;
    logic [DW-1:0] lit;
    logic          z, n, c, v;
    logic [UW-1:0] user;
  } instr_t;

  typedef struct {
    logic          taken;
    logic [AW-1:0] target;
    logic [DW-1:0] link;
    logic          link_we;
    logic          misalign;
    logic [UW-1:0] user;
  } res_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  w0rm_core_branch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .USER_WIDTH(UW)) bus ();

  w0rm_core_branch_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .USER_WIDTH(UW), .INSTR_BYTES(IB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Conditions come in pairs: odd codes invert the even code below them.
  function automatic res_t model(instr_t i);
    res_t r;
    logic base_c;
    logic hit;
    longint unsigned t;
    longint unsigned modv;
    modv = 64'd1 << AW;
    case (i.cc[3:1])
      3'd0:    base_c = i.z;
      3'd1:    base_c = i.c;
      3'd2:    base_c = i.v;
      3'd3:    base_c = i.n;
      3'd4:    base_c = i.c && !i.z;
      3'd5:    base_c = (i.n == i.v);
      3'd6:    base_c = !i.z && (i.n == i.v);
      default: base_c = 1'b1;
    endcase
    hit = i.cc[0] ? !base_c : base_c;
    case (i.mode)
      2'd0:    t = 64'(i.rn);
      2'd1:    t = 64'(i.base) + 64'(i.lit);
      2'd2:    t = 64'(i.rn) + 64'(i.lit);
      default: t = 64'd0;
    endcase
    t = t % modv;
    r.taken = i.is_branch && hit && (i.mode != 2'd3);
    r.target = '0;
    r.link = '0;
    r.link_we = 1'b0;
    r.misalign = 1'b0;
    r.user = i.user;
    if (r.taken) begin
      r.target = AW'(t);
      r.link = DW'((64'(i.base) + 64'(IB)) % modv);
      r.link_we = i.link_en;
    end
`ifdef W0RM_BRANCH_ALIGN_CHECK_EN
    if (r.taken && (t % 64'(IB)) != 0) begin
      r.taken = 1'b0;
      r.misalign = 1'b1;
      r.link = '0;
      r.link_we = 1'b0;
    end
`endif
    return r;
  endfunction

  function automatic logic [VW-1:0] exp_vec(res_t r);
    return {r.taken, r.target, r.link, r.link_we, r.user, r.misalign};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    logic mis;
`ifdef W0RM_BRANCH_ALIGN_CHECK_EN
    mis = bus.out_misalign;
`else
    mis = 1'b0;
`endif
    return {bus.out_taken, bus.out_target, bus.out_link, bus.out_link_we, bus.user_out, mis};
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.is_branch = ($urandom_range(0, 3) != 0);
    i.cc = 4'($urandom_range(0, 15));
    i.mode = 2'($urandom_range(0, 3));
    i.link_en = 1'($urandom_range(0, 1));
    i.base = AW'($urandom);
    i.rn = DW'($urandom);
    i.lit = DW'($urandom);
    i.z = 1'($urandom_range(0, 1));
    i.n = 1'($urandom_range(0, 1));
    i.c = 1'($urandom_range(0, 1));
    i.v = 1'($urandom_range(0, 1));
    i.user = UW'($urandom);
    return i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input instr_t i);
    bus.in_valid = 1'b1;
    bus.is_branch = i.is_branch;
    bus.cond_code = i.cc;
    bus.target_mode = i.mode;
    bus.link_en = i.link_en;
    bus.base_addr = i.base;
    bus.rn = i.rn;
    bus.lit = i.lit;
    bus.flag_z = i.z;
    bus.flag_n = i.n;
    bus.flag_c = i.c;
    bus.flag_v = i.v;
    bus.user_in = i.user;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush_in = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    step();
    step();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (dut_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", dut_vec()); else n_pass++;
    n_checks++; if (bus.flush_pipeline !== 1'b0) $display("FAIL reset_flush: got %0b want 0", bus.flush_pipeline); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_eq_mode1();
    instr_t i;
    i = '{is_branch: 1'b1, cc: 4'd0, mode: 2'd1, link_en: 1'b1, base: 32'h100, rn: 32'h55,
          lit: 32'hFFFF_FFF0, z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0, user: 3'd5};
    bus.out_ready = 1'b1;
    present(i);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL eq_in_ready: got %0b want 1", bus.in_ready); else n_pass++;
    step();
    idle();
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL eq_early_valid: got %0b want 0", bus.out_valid); else n_pass++;
    step();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL eq_valid: got %0b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_taken !== 1'b1) $display("FAIL eq_taken: got %0b want 1", bus.out_taken); else n_pass++;
    n_checks++; if (bus.out_target !== 32'h0F0) $display("FAIL eq_target: got %h want 000000f0", bus.out_target); else n_pass++;
    n_checks++; if (bus.out_link !== 32'h102) $display("FAIL eq_link: got %h want 00000102", bus.out_link); else n_pass++;
    n_checks++; if (bus.out_link_we !== 1'b1) $display("FAIL eq_link_we: got %0b want 1", bus.out_link_we); else n_pass++;
    n_checks++; if (bus.user_out !== 3'd5) $display("FAIL eq_user: got %0d want 5", bus.user_out); else n_pass++;
    n_checks++; if (bus.flush_pipeline !== 1'b1) $display("FAIL eq_flush: got %0b want 1", bus.flush_pipeline); else n_pass++;
    step();
    n_checks++; if (bus.flush_pipeline !== 1'b0) $display("FAIL eq_flush_once: got %0b want 0", bus.flush_pipeline); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL eq_valid_drop: got %0b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_gt_le();
    instr_t gt;
    instr_t le;
    gt = '{is_branch: 1'b1, cc: 4'd12, mode: 2'd0, link_en: 1'b1, base: 32'h300, rn: 32'h200,
           lit: 32'h0, z: 1'b0, n: 1'b1, c: 1'b0, v: 1'b1, user: 3'd2};
    le = gt;
    le.cc = 4'd13;
    le.user = 3'd4;
    bus.out_ready = 1'b1;
    present(gt);
    step();
    present(le);
    step();
    idle();
    #1;
    n_checks++; if ({bus.out_valid, bus.out_taken} !== 2'b11) $display("FAIL gt_taken: got %b want 11", {bus.out_valid, bus.out_taken}); else n_pass++;
    n_checks++; if ({bus.out_target, bus.out_link} !== {32'h200, 32'h302}) $display("FAIL gt_target_link: got %h want 0000020000000302", {bus.out_target, bus.out_link}); else n_pass++;
    n_checks++; if (bus.flush_pipeline !== 1'b1) $display("FAIL gt_flush: got %0b want 1", bus.flush_pipeline); else n_pass++;
    step();
    n_checks++; if ({bus.out_valid, bus.out_taken} !== 2'b10) $display("FAIL le_not_taken: got %b want 10", {bus.out_valid, bus.out_taken}); else n_pass++;
    n_checks++; if ({bus.out_target, bus.out_link, bus.out_link_we} !== '0) $display("FAIL le_zero_fields: got %h want 0", {bus.out_target, bus.out_link, bus.out_link_we}); else n_pass++;
    n_checks++; if (bus.flush_pipeline !== 1'b0) $display("FAIL le_flush: got %0b want 0", bus.flush_pipeline); else n_pass++;
    n_checks++; if (bus.user_out !== 3'd4) $display("FAIL le_user: got %0d want 4", bus.user_out); else n_pass++;
    step();
  endtask

  task automatic test_wrap_reserved();
    instr_t w;
    instr_t r;
    w = '{is_branch: 1'b1, cc: 4'd14, mode: 2'd2, link_en: 1'b0, base: 32'h40, rn: 32'hFFFF_FFFE,
          lit: 32'h4, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0, user: 3'd1};
    r = w;
    r.mode = 2'd3;
    bus.out_ready = 1'b1;
    present(w);
    step();
    present(r);
    step();
    idle();
    #1;
    n_checks++; if ({bus.out_taken, bus.out_target} !== {1'b1, 32'h2}) $display("FAIL wrap_target: got %h want 1_00000002", {bus.out_taken, bus.out_target}); else n_pass++;
    n_checks++; if (bus.out_link_we !== 1'b0) $display("FAIL wrap_link_we: got %0b want 0", bus.out_link_we); else n_pass++;
    step();
    n_checks++; if ({bus.out_valid, bus.out_taken, bus.out_target} !== {2'b10, 32'h0}) $display("FAIL reserved_mode: got %h want 2_00000000", {bus.out_valid, bus.out_taken, bus.out_target}); else n_pass++;
    n_checks++; if (bus.flush_pipeline !== 1'b0) $display("FAIL reserved_flush: got %0b want 0", bus.flush_pipeline); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    instr_t seq[3];
    res_t   exp_q[$];
    int     got;
    logic   c_acc;
    for (int k = 0; k < 3; k++) begin
      seq[k] = rand_instr();
      seq[k].is_branch = 1'b1;
      seq[k].cc = 4'd14;
      seq[k].user = UW'(k + 1);
      exp_q.push_back(model(seq[k]));
    end
    bus.out_ready = 1'b0;
    present(seq[0]);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready0: got %0b want 1", bus.in_ready); else n_pass++;
    step();
    present(seq[1]);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready1: got %0b want 1", bus.in_ready); else n_pass++;
    step();
    present(seq[2]);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_ready_full: got %0b want 0", bus.in_ready); else n_pass++;
    step();
    #1;
    n_checks++; if ({bus.in_ready, bus.out_valid} !== 2'b01) $display("FAIL b2b_stall_hold: got %b want 01", {bus.in_ready, bus.out_valid}); else n_pass++;
    n_checks++; if (bus.flush_pipeline !== 1'b0) $display("FAIL b2b_stall_flush: got %0b want 0", bus.flush_pipeline); else n_pass++;
    step();
    bus.out_ready = 1'b1;
    got = 0;
    c_acc = 1'b0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      #1;
      if (bus.in_valid && bus.in_ready) c_acc = 1'b1;
      if (bus.out_valid) begin
        n_checks++; if (dut_vec() !== exp_vec(exp_q[got])) $display("FAIL b2b_result%0d: got %h want %h", got, dut_vec(), exp_vec(exp_q[got])); else n_pass++;
        n_checks++; if (bus.flush_pipeline !== exp_q[got].taken) $display("FAIL b2b_flush%0d: got %0b want %0b", got, bus.flush_pipeline, exp_q[got].taken); else n_pass++;
        got++;
      end
      step();
      if (c_acc) bus.in_valid = 1'b0;
    end
    n_checks++; if (got !== 3) $display("FAIL b2b_count: got %0d want 3", got); else n_pass++;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_no_dup: got %0b want 0", bus.out_valid); else n_pass++;
    idle();
    step();
  endtask

  task automatic test_flush();
    instr_t a;
    a = '{is_branch: 1'b1, cc: 4'd14, mode: 2'd0, link_en: 1'b1, base: 32'h10, rn: 32'h40,
          lit: 32'h0, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0, user: 3'd3};
    bus.out_ready = 1'b0;
    present(a);
    step();
    step();
    bus.out_ready = 1'b1;
    bus.flush_in = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL flush_pre_valid: got %0b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready: got %0b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.flush_pipeline !== 1'b0) $display("FAIL flush_no_pulse: got %0b want 0", bus.flush_pipeline); else n_pass++;
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL flush_drop%0d: got %0b want 0", k, bus.out_valid); else n_pass++;
      step();
    end
  endtask

  task automatic test_misalign();
    instr_t i;
    i = '{is_branch: 1'b1, cc: 4'd14, mode: 2'd0, link_en: 1'b1, base: 32'h500, rn: 32'h101,
          lit: 32'h0, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0, user: 3'd6};
    bus.out_ready = 1'b1;
    present(i);
    step();
    idle();
    step();
`ifdef W0RM_BRANCH_ALIGN_CHECK_EN
    n_checks++; if ({bus.out_misalign, bus.out_taken, bus.out_link_we} !== 3'b100) $display("FAIL misalign_flags: got %b want 100", {bus.out_misalign, bus.out_taken, bus.out_link_we}); else n_pass++;
    n_checks++; if (bus.out_target !== 32'h101) $display("FAIL misalign_target: got %h want 00000101", bus.out_target); else n_pass++;
    n_checks++; if (bus.flush_pipeline !== 1'b0) $display("FAIL misalign_flush: got %0b want 0", bus.flush_pipeline); else n_pass++;
`else
    n_checks++; if ({bus.out_taken, bus.out_link_we} !== 2'b11) $display("FAIL unaligned_taken: got %b want 11", {bus.out_taken, bus.out_link_we}); else n_pass++;
    n_checks++; if ({bus.out_target, bus.out_link} !== {32'h101, 32'h502}) $display("FAIL unaligned_target: got %h want 0000010100000502", {bus.out_target, bus.out_link}); else n_pass++;
    n_checks++; if (bus.flush_pipeline !== 1'b1) $display("FAIL unaligned_flush: got %0b want 1", bus.flush_pipeline); else n_pass++;
`endif
    step();
  endtask

  task automatic test_random();
    res_t   q[$];
    res_t   e;
    instr_t i;
    for (int cyc = 0; cyc < 400; cyc++) begin
      i = rand_instr();
      present(i);
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      n_checks++; if (bus.in_ready !== (q.size() < 2 || bus.out_ready)) $display("FAIL rnd_in_ready: got %0b want %0b (cycle %0d)", bus.in_ready, (q.size() < 2 || bus.out_ready), cyc); else n_pass++;
      if (q.size() == 0) begin
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rnd_spurious_valid: got %0b want 0 (cycle %0d)", bus.out_valid, cyc); else n_pass++;
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        e = q.pop_front();
        n_checks++; if (dut_vec() !== exp_vec(e)) $display("FAIL rnd_result: got %h want %h (cycle %0d)", dut_vec(), exp_vec(e), cyc); else n_pass++;
        n_checks++; if (bus.flush_pipeline !== e.taken) $display("FAIL rnd_flush: got %0b want %0b (cycle %0d)", bus.flush_pipeline, e.taken, cyc); else n_pass++;
      end else begin
        n_checks++; if (bus.flush_pipeline !== 1'b0) $display("FAIL rnd_idle_flush: got %0b want 0 (cycle %0d)", bus.flush_pipeline, cyc); else n_pass++;
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(i));
      step();
    end
    idle();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && q.size() > 0; cyc++) begin
      #1;
      if (bus.out_valid) begin
        e = q.pop_front();
        n_checks++; if (dut_vec() !== exp_vec(e)) $display("FAIL rnd_drain: got %h want %h", dut_vec(), exp_vec(e)); else n_pass++;
      end
      step();
    end
    n_checks++; if (q.size() !== 0) $display("FAIL rnd_leftover: got %0d pending want 0", q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    instr_t i;
    i = rand_instr();
    i.user = 3'd7;
    bus.out_ready = 1'b0;
    present(i);
    step();
    step();
    idle();
    #1;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL rst_pre_valid: got %0b want 1", bus.out_valid); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({bus.out_valid, bus.user_out, bus.out_taken} !== '0) $display("FAIL rst_async_clear: got %h want 0", {bus.out_valid, bus.user_out, bus.out_taken}); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", bus.in_ready); else n_pass++;
    step();
    reset_n = 1'b1;
    step();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_after_release: got %0b want 0", bus.out_valid); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.is_branch = 1'b0;
    bus.cond_code = '0;
    bus.target_mode = '0;
    bus.link_en = 1'b0;
    bus.base_addr = '0;
    bus.rn = '0;
    bus.lit = '0;
    bus.flag_z = 1'b0;
    bus.flag_n = 1'b0;
    bus.flag_c = 1'b0;
    bus.flag_v = 1'b0;
    bus.flush_in = 1'b0;
    bus.user_in = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_eq_mode1();
    test_gt_le();
    test_wrap_reserved();
    test_back_to_back();
    test_flush();
    test_misalign();
    test_random();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
